// File: rtl/xyz_pkg.sv
// Shared types and constants for the XYZ beam scheduler and its sample FIFO.
package xyz_pkg;

  localparam int SAMPLE_XW = 10;
  localparam int SAMPLE_ZW = 4;
  localparam int CENTRE    = 1 << (SAMPLE_XW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2,
    PARK   = 2'd3
  } state_t;

  typedef struct packed {
    logic [SAMPLE_XW-1:0] x;
    logic [SAMPLE_XW-1:0] y;
    logic [SAMPLE_ZW-1:0] z;
  } sample_t;

endpackage

// File: rtl/xyz_sample_fifo.sv
// Synchronous sample FIFO with occupancy; full/empty derive from registered pointers.
module xyz_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk_25,
  input  logic                     RESET_L,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_25) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/xyz_beam_scheduler.sv
// Paces buffered vector samples onto the X/Y/Z beam DACs with blanked settle,
// lit dwell and a blanked park at screen centre when starved.
//
// state  | meaning
// IDLE   | waiting for a sample; pops the FIFO head, counts starvation cycles
// SETTLE | beam blanked while the deflection settles after a move or jump
// DWELL  | lit point held on screen
// PARK   | starved: beam blanked at centre until a sample arrives
module xyz_beam_scheduler
  import xyz_pkg::*;
#(
  parameter int XW         = SAMPLE_XW,
  parameter int ZW         = SAMPLE_ZW,
  parameter int DEPTH      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_CYC  = 2,
  parameter int JUMP_TH    = 64,
  parameter int PARK_CYC   = 1024
) (
  input  logic                   clk_25,
  input  logic                   RESET_L,
  input  logic                   xyz_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XW-1:0]          in_x,
  input  logic [XW-1:0]          in_y,
  input  logic [ZW-1:0]          in_z,
  output logic [XW-1:0]          out_x,
  output logic [XW-1:0]          out_y,
  output logic [ZW-1:0]          out_z,
  output logic                   out_strobe,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   parked
);

  localparam logic [XW-1:0] CTR     = XW'(CENTRE);
  localparam int            CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
  localparam int            CW      = $clog2(CNT_MAX + 1);
  localparam int            IW      = $clog2(PARK_CYC + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idle_cnt;
  logic            pending_lit;
  logic [ZW-1:0]   lit_z;

  sample_t         wr_s;
  sample_t         head;
  logic [$bits(sample_t)-1:0] rd_data;
  logic            full;
  logic            empty;
  logic            fifo_push;
  logic            fifo_pop;

  logic signed [XW:0] dx;
  logic signed [XW:0] dy;
  logic [XW:0]        adx;
  logic [XW:0]        ady;
  logic               need_settle;

  assign in_ready  = ~full | ~xyz_en;
  assign fifo_push = in_valid & xyz_en;
  assign fifo_pop  = xyz_en & (state == IDLE) & ~empty;
  assign wr_s      = '{x: in_x, y: in_y, z: in_z};
  assign head      = sample_t'(rd_data);

  xyz_sample_fifo #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_25  (clk_25),
    .RESET_L (RESET_L),
    .flush   (~xyz_en),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (wr_s),
    .rd_data (rd_data),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  // Jump distance against the current beam position, one extra bit so the
  // unsigned coordinates subtract without wrapping.
  assign dx  = $signed({1'b0, head.x}) - $signed({1'b0, out_x});
  assign dy  = $signed({1'b0, head.y}) - $signed({1'b0, out_y});
  assign adx = dx[XW] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[XW] ? $unsigned(-dy) : $unsigned(dy);

  assign need_settle = (adx > (XW+1)'(JUMP_TH)) || (ady > (XW+1)'(JUMP_TH)) ||
                       (out_z == '0) || parked;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      state       <= IDLE;
      cnt         <= '0;
      idle_cnt    <= '0;
      pending_lit <= 1'b0;
      lit_z       <= '0;
      out_x       <= CTR;
      out_y       <= CTR;
      out_z       <= '0;
      out_strobe  <= 1'b0;
      parked      <= 1'b1;
    end else if (!xyz_en) begin
      // Beam position holds; only intensity and sequencing are cleared.
      state       <= IDLE;
      cnt         <= '0;
      idle_cnt    <= '0;
      pending_lit <= 1'b0;
      lit_z       <= '0;
      out_z       <= '0;
      out_strobe  <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            idle_cnt   <= '0;
            parked     <= 1'b0;
            out_x      <= head.x;
            out_y      <= head.y;
            out_strobe <= 1'b1;
            if (head.z == '0) begin
              out_z       <= '0;
              pending_lit <= 1'b0;
              cnt         <= CW'(SETTLE_CYC - 1);
              state       <= SETTLE;
            end else if (need_settle) begin
              out_z       <= '0;
              lit_z       <= head.z;
              pending_lit <= 1'b1;
              cnt         <= CW'(SETTLE_CYC - 1);
              state       <= SETTLE;
            end else begin
              out_z <= head.z;
              cnt   <= CW'(DWELL_CYC - 1);
              state <= DWELL;
            end
          end else if (idle_cnt == IW'(PARK_CYC - 1)) begin
            idle_cnt   <= '0;
            out_x      <= CTR;
            out_y      <= CTR;
            out_z      <= '0;
            out_strobe <= 1'b1;
            parked     <= 1'b1;
            state      <= PARK;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            if (pending_lit) begin
              out_z       <= lit_z;
              out_strobe  <= 1'b1;
              pending_lit <= 1'b0;
              cnt         <= CW'(DWELL_CYC - 1);
              state       <= DWELL;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DWELL: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        PARK: begin
          if (!empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xyz_beam_scheduler.sv
// Directed bench for xyz_beam_scheduler: park timing, settle/dwell pacing, FIFO order and enable flush.
module tb_xyz_beam_scheduler;

  logic       clk_25 = 1'b0;
  logic       RESET_L;
  logic       xyz_en;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_x, in_y;
  logic [3:0] in_z;
  logic [9:0] out_x, out_y;
  logic [3:0] out_z;
  logic       out_strobe;
  logic [4:0] fifo_level;
  logic       parked;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int pcyc;
  int p0;
  bit saw_full;
  bit ready_bad;

  logic [23:0] sq[$];
  int          st[$];

  xyz_beam_scheduler dut (
    .clk_25     (clk_25),
    .RESET_L    (RESET_L),
    .xyz_en     (xyz_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_z       (in_z),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_z      (out_z),
    .out_strobe (out_strobe),
    .fifo_level (fifo_level),
    .parked     (parked)
  );

  always #5 clk_25 = ~clk_25;

  always @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Strobe log: entry and the clock edge index after which it appeared.
  always @(posedge clk_25) begin
    #1;
    if (RESET_L) begin
      if (out_strobe) begin
        sq.push_back({out_x, out_y, out_z});
        st.push_back(cyc);
      end
      if (xyz_en && fifo_level == 5'd16) begin
        saw_full = 1'b1;
        if (in_ready) ready_bad = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] smp(input int x, input int y, input int z);
    return {10'(x), 10'(y), 4'(z)};
  endfunction

  function automatic logic [23:0] qe(input int i);
    if (i < sq.size()) return sq[i];
    return 24'bx;
  endfunction

  function automatic int ts(input int i);
    if (i < st.size()) return st[i];
    return -1000;
  endfunction

  task automatic clr();
    sq.delete();
    st.delete();
  endtask

  task automatic push(input logic [9:0] x, input logic [9:0] y, input logic [3:0] z);
    int n;
    n = 0;
    @(negedge clk_25);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_z = z;
    while (!in_ready && n < 300) begin
      @(negedge clk_25);
      n++;
    end
    chk("push_accept", 32'(n < 300), 32'd1);
    pcyc = cyc + 1;
    @(posedge clk_25);
  endtask

  task automatic idle();
    @(negedge clk_25);
    in_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (sq.size() < n && k < budget) begin
      @(negedge clk_25);
      k++;
    end
  endtask

  initial begin
    RESET_L  = 1'b0;
    xyz_en   = 1'b1;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_z     = '0;
    saw_full = 1'b0;
    ready_bad = 1'b0;

    // Reset values
    #23;
    chk("rst_out_x", 32'(out_x), 32'd512);
    chk("rst_out_y", 32'(out_y), 32'd512);
    chk("rst_out_z", 32'(out_z), 32'd0);
    chk("rst_strobe", 32'(out_strobe), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_parked", 32'(parked), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Starvation: one park strobe at idle edge 1024
    @(negedge clk_25);
    RESET_L = 1'b1;
    repeat (1100) @(negedge clk_25);
    chk("park_count", 32'(sq.size()), 32'd1);
    chk("park_time", 32'(ts(0)), 32'd1024);
    chk("park_pos", 32'(qe(0)), 32'(smp(512, 512, 0)));
    chk("park_flag", 32'(parked), 32'd1);

    // Lit point out of park: blanked strobe then lit 8 cycles later
    clr();
    push(10'd100, 10'd100, 4'd8);
    p0 = pcyc;
    idle();
    wait_strobes(2, 40);
    chk("unpark_blank", 32'(qe(0)), 32'(smp(100, 100, 0)));
    chk("unpark_lit", 32'(qe(1)), 32'(smp(100, 100, 8)));
    chk("unpark_pop_time", 32'(ts(0) - p0), 32'd2);
    chk("unpark_settle", 32'(ts(1) - ts(0)), 32'd8);
    chk("unpark_parked", 32'(parked), 32'd0);

    // Near lit points: direct strobes, DWELL_CYC+1 spacing
    repeat (5) @(negedge clk_25);
    clr();
    push(10'd120, 10'd130, 4'd5);
    p0 = pcyc;
    push(10'd121, 10'd131, 4'd5);
    idle();
    wait_strobes(2, 40);
    repeat (10) @(negedge clk_25);
    chk("near_count", 32'(sq.size()), 32'd2);
    chk("near_first", 32'(qe(0)), 32'(smp(120, 130, 5)));
    chk("near_second", 32'(qe(1)), 32'(smp(121, 131, 5)));
    chk("near_latency", 32'(ts(0) - p0), 32'd1);
    chk("near_spacing", 32'(ts(1) - ts(0)), 32'd3);

    // Far lit point: settle inserted
    clr();
    push(10'd300, 10'd130, 4'd5);
    idle();
    wait_strobes(2, 40);
    chk("jump_blank", 32'(qe(0)), 32'(smp(300, 130, 0)));
    chk("jump_lit", 32'(qe(1)), 32'(smp(300, 130, 5)));
    chk("jump_settle", 32'(ts(1) - ts(0)), 32'd8);

    // Burst of 20 blanked moves: FIFO fills, order preserved
    repeat (15) @(negedge clk_25);
    clr();
    saw_full  = 1'b0;
    ready_bad = 1'b0;
    for (int i = 0; i < 20; i++) push(10'(i * 37 + 5), 10'(1000 - i * 41), 4'd0);
    idle();
    wait_strobes(20, 400);
    chk("burst_full_seen", 32'(saw_full), 32'd1);
    chk("burst_ready_when_full", 32'(ready_bad), 32'd0);
    chk("burst_count", 32'(sq.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("burst_order_%0d", i), 32'(qe(i)), 32'(smp(i * 37 + 5, 1000 - i * 41, 0)));

    // Blanked move then lit neighbour: 8 blank cycles, lit point needs settle
    repeat (15) @(negedge clk_25);
    clr();
    push(10'd700, 10'd40, 4'd0);
    p0 = pcyc;
    push(10'd705, 10'd45, 4'd3);
    idle();
    wait_strobes(3, 60);
    repeat (5) @(negedge clk_25);
    chk("move_count", 32'(sq.size()), 32'd3);
    chk("move_entry", 32'(qe(0)), 32'(smp(700, 40, 0)));
    chk("move_latency", 32'(ts(0) - p0), 32'd1);
    chk("move_blank_gap", 32'(ts(1) - ts(0)), 32'd9);
    chk("move_next_blank", 32'(qe(1)), 32'(smp(705, 45, 0)));
    chk("move_next_lit", 32'(qe(2)), 32'(smp(705, 45, 3)));
    chk("move_next_settle", 32'(ts(2) - ts(1)), 32'd8);

    // Disable mid-DWELL with 10 queued entries
    repeat (10) @(negedge clk_25);
    clr();
    push(10'd900, 10'd900, 4'd7);
    for (int i = 0; i < 10; i++) push(10'(890 + i), 10'd900, 4'd7);
    @(negedge clk_25);
    in_valid = 1'b0;
    chk("dis_level_before", 32'(fifo_level), 32'd10);
    chk("dis_lit_before", 32'(out_z), 32'd7);
    xyz_en = 1'b0;
    #1;
    chk("dis_ready_comb", 32'(in_ready), 32'd1);
    @(negedge clk_25);
    chk("dis_level", 32'(fifo_level), 32'd0);
    chk("dis_out_z", 32'(out_z), 32'd0);
    chk("dis_ready", 32'(in_ready), 32'd1);
    chk("dis_hold_x", 32'(out_x), 32'd900);
    chk("dis_hold_y", 32'(out_y), 32'd900);
    chk("dis_strobes", 32'(sq.size()), 32'd2);
    in_valid = 1'b1;
    in_x = 10'd1;
    in_y = 10'd2;
    in_z = 4'd3;
    @(negedge clk_25);
    chk("dis_discard", 32'(fifo_level), 32'd0);
    in_valid = 1'b0;
    xyz_en = 1'b1;
    @(negedge clk_25);
    clr();
    push(10'd905, 10'd905, 4'd6);
    idle();
    wait_strobes(2, 40);
    chk("reen_blank", 32'(qe(0)), 32'(smp(905, 905, 0)));
    chk("reen_lit", 32'(qe(1)), 32'(smp(905, 905, 6)));
    chk("reen_settle", 32'(ts(1) - ts(0)), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xyz_beam_scheduler.md
Name: xyz_beam_scheduler

Overview:
- Sequences point samples from the vector generator onto the X/Y/Z beam DAC outputs at a controlled rate.
- Buffers samples in a small FIFO. Inserts blanked settle time on beam jumps and holds each lit point for a dwell time.
- Parks the beam blanked at screen centre when starved.
- Sits between the vector generator and the VGA_X/VGA_Y/VGA_Z pins; gated by the XYZ enable from the OSD.

Parameters:
- XW, 10, X/Y coordinate width.
- ZW, 4, intensity width.
- DEPTH, 16, FIFO entries (power of 2).
- SETTLE_CYC, 8, blanked cycles after a move or jump.
- DWELL_CYC, 2, cycles each lit point is held.
- JUMP_TH, 64, per-axis distance above which a lit point first needs a blanked settle.
- PARK_CYC, 1024, empty-FIFO idle cycles before the beam parks.

Ports:
- clk_25  in  1  system clock.
- RESET_L  in  1  reset, asynchronous, active-low.
- xyz_en  in  1  1 = scheduler active; 0 = flush and blank.
- in_valid  in  1  sample offered.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- in_x  in  XW  sample X.
- in_y  in  XW  sample Y.
- in_z  in  ZW  sample intensity; 0 = blanked move.
- out_x  out  XW  beam X.
- out_y  out  XW  beam Y.
- out_z  out  ZW  beam intensity.
- out_strobe  out  1  one-cycle pulse when out_x/y/z take a new value.
- fifo_level  out  log2(DEPTH)+1  occupancy.
- parked  out  1  beam is at park position.

Behaviour:
- Reset (RESET_L=0, asynchronous):
  - out_x = out_y = 2^(XW-1) (512); out_z = 0.
  - out_strobe = 0; fifo_level = 0; parked = 1; state IDLE.
  - All counters 0. Leaving reset is synchronous to clk_25.
- FIFO:
  - in_ready = !full | !xyz_en.
  - A push occurs on a handshake with xyz_en=1. A push in cycle N is poppable in cycle N+1.
  - Simultaneous push and pop when not full: both happen; level unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle (registered full).
- States: IDLE, SETTLE, DWELL, PARK. One shared down-counter cnt.
- IDLE, FIFO non-empty: pop the head entry (x,y,z). Outputs register the next cycle with out_strobe=1.
  - z==0: out_x/y = entry, out_z = 0; cnt = SETTLE_CYC-1; go SETTLE (pending_lit = 0).
  - z!=0 and (|x-out_x| > JUMP_TH or |y-out_y| > JUMP_TH or out_z==0 or parked): out_x/y = entry, out_z = 0; latch z; cnt = SETTLE_CYC-1; go SETTLE (pending_lit = 1).
    - Compute the distance as XW+1-bit signed subtract, then absolute value.
  - otherwise: out_x/y/z = entry; cnt = DWELL_CYC-1; go DWELL.
- IDLE, FIFO empty: increment idle counter. At PARK_CYC go PARK.
- SETTLE: decrement cnt. At 0:
  - pending_lit: out_z = latched z, out_strobe=1, cnt = DWELL_CYC-1, go DWELL.
  - else: go IDLE.
- DWELL: decrement cnt. At 0, go IDLE; the next pop is evaluated in that IDLE cycle.
- PARK: out_x = out_y = 512, out_z = 0, out_strobe=1 once, parked=1.
  - Stay until FIFO is non-empty, then go IDLE.
  - parked clears on the next strobe from a popped entry.
- Idle counter clears on any pop.
- Throughput: a lit point within JUMP_TH of a lit predecessor costs DWELL_CYC+1 cycles.
- xyz_en=0 (sampled synchronously):
  - Next cycle: FIFO flushed (level 0), out_z = 0, state IDLE, counters cleared; out_x/y hold.
  - Inputs are accepted and discarded.
  - Re-enable starts from IDLE with an empty FIFO.
- Reset mid-operation: immediate return to reset values; FIFO contents are lost.
- Coordinates are unsigned with no wrap: values pass through unmodified.

Decomposition:
- Package xyz_pkg holds:
  - state enum {IDLE, SETTLE, DWELL, PARK};
  - CENTRE = 2^(XW-1);
  - the sample struct {x, y, z}.
- One sub-module, xyz_sample_fifo: synchronous FIFO, DEPTH × (2·XW+ZW), with level, full and empty, and asynchronous active-low reset on pointers.
- The scheduler FSM and distance compare stay in the parent.

Test Plan:
- Reset then idle 1100 cycles with no input -> out_x=out_y=512, out_z=0, parked=1, and exactly one strobe, at idle cycle 1024.
- Push lit (100,100,z=8) while parked -> blanked strobe at (100,100,0), 8 cycles later strobe z=8, held 2 cycles, then IDLE.
- After that, push lit (120,130,z=5) -> direct strobe (120,130,5) in the cycle after the pop, with no settle; push (300,130,z=5) -> settle inserted because dx=180>64.
- Push 20 samples back-to-back with the scheduler busy -> in_ready drops when fifo_level=16; no sample is lost or reordered; output order equals input order.
- Push z=0 move (700,40,0) -> strobe (700,40,0), 8 blank cycles, no lit strobe.
- Deassert xyz_en with 10 entries queued mid-DWELL -> next cycle fifo_level=0, out_z=0, in_ready=1; re-enable and push one sample -> normal scheduling resumes.
